// File: rtl/icache_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// icache_prefetch_buffer
//   Single-entry next-line prefetch buffer between the instruction cache and
//   the memory arbiter. Icache misses are forwarded to the arbiter. After each
//   response the following 32-byte line is fetched into a local buffer, so a
//   later miss to that line is answered without an arbiter round trip.
//   At most one arbiter request is outstanding.
//
// Parameters
//   PREFETCH_EN     1: issue next-line prefetches, 0: registered pass-through
//
// Ports
//   clk             clock, rising edge
//   reset_n         asynchronous active-low reset
//   icache_read     line read request, held with icache_address until resp
//   icache_address  request address, bits [4:0] ignored
//   icache_resp     single-cycle response pulse
//   icache_rdata    line data, zero outside the response cycle
//   arb_read        downstream read, held with arb_address until arb_resp
//   arb_address     line-aligned downstream address, zero when idle
//   arb_resp        downstream completion pulse
//   arb_rdata       downstream line, valid with arb_resp
//   pf_hits         saturating count of requests served from the buffer
// ---------------------------------------------------------------------------
module icache_prefetch_buffer #(
    parameter bit PREFETCH_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         icache_read,
    input  logic [31:0]  icache_address,
    output logic         icache_resp,
    output logic [255:0] icache_rdata,
    output logic         arb_read,
    output logic [31:0]  arb_address,
    input  logic         arb_resp,
    input  logic [255:0] arb_rdata,
    output logic [31:0]  pf_hits
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEMAND   = 2'd1,
        S_RESP     = 2'd2,
        S_PREFETCH = 2'd3
    } state_t;

    state_t         r_state;
    logic [255:0]   r_buf_line;
    logic [26:0]    r_buf_tag;
    logic           r_buf_valid;
    logic [26:0]    r_req_tag;
    logic [255:0]   r_out_line;
    logic [31:0]    r_pf_hits;
    logic           r_arb_read;
    logic [31:0]    r_arb_address;
    logic           r_icache_resp;

    logic [26:0]    w_tag;
    logic [26:0]    w_next_tag;
    logic           w_hit;
    logic           w_unused;

    assign w_tag      = icache_address[31:5];
    assign w_next_tag = r_req_tag + 27'd1;
    assign w_hit      = r_buf_valid && (r_buf_tag == w_tag);
    assign w_unused   = ^icache_address[4:0];

    assign icache_resp  = r_icache_resp;
    // out_line keeps its value after RESP; gating keeps the bus zero elsewhere
    assign icache_rdata = r_icache_resp ? r_out_line : 256'd0;
    assign arb_read     = r_arb_read;
    assign arb_address  = r_arb_address;
    assign pf_hits      = r_pf_hits;

    // Outputs are computed together with the next state so that they are
    // flops; the async reset therefore drops arb_read without waiting a clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_buf_line    <= '0;
            r_buf_tag     <= '0;
            r_buf_valid   <= 1'b0;
            r_req_tag     <= '0;
            r_out_line    <= '0;
            r_pf_hits     <= '0;
            r_arb_read    <= 1'b0;
            r_arb_address <= '0;
            r_icache_resp <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (icache_read) begin
                        r_req_tag <= w_tag;
                        if (w_hit) begin
                            r_out_line    <= r_buf_line;
                            r_icache_resp <= 1'b1;
                            if (r_pf_hits != 32'hFFFF_FFFF)
                                r_pf_hits <= r_pf_hits + 32'd1;
                            r_state       <= S_RESP;
                        end else begin
                            r_arb_read    <= 1'b1;
                            r_arb_address <= {w_tag, 5'b0};
                            r_state       <= S_DEMAND;
                        end
                    end
                end
                S_DEMAND: begin
                    if (arb_resp) begin
                        r_out_line    <= arb_rdata;
                        r_arb_read    <= 1'b0;
                        r_arb_address <= '0;
                        r_icache_resp <= 1'b1;
                        r_state       <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_icache_resp <= 1'b0;
                    // The last line of the address space has no successor.
                    if (PREFETCH_EN && (r_req_tag != 27'h7FF_FFFF)) begin
                        r_buf_valid   <= 1'b0;
                        r_buf_tag     <= w_next_tag;
                        r_arb_read    <= 1'b1;
                        r_arb_address <= {w_next_tag, 5'b0};
                        r_state       <= S_PREFETCH;
                    end else begin
                        r_state       <= S_IDLE;
                    end
                end
                S_PREFETCH: begin
                    // Icache requests wait here; the arbiter handshake cannot
                    // be aborted, and IDLE re-evaluates them against the
                    // freshly filled buffer.
                    if (arb_resp) begin
                        r_buf_line    <= arb_rdata;
                        r_buf_valid   <= 1'b1;
                        r_arb_read    <= 1'b0;
                        r_arb_address <= '0;
                        r_state       <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_prefetch_buffer.sv
module tb_icache_prefetch_buffer;

    logic         clk;
    logic         reset_n;

    logic         icache_read;
    logic [31:0]  icache_address;
    logic         icache_resp;
    logic [255:0] icache_rdata;
    logic         arb_read;
    logic [31:0]  arb_address;
    logic         arb_resp;
    logic [255:0] arb_rdata;
    logic [31:0]  pf_hits;

    logic         np_read;
    logic [31:0]  np_address;
    logic         np_resp;
    logic [255:0] np_rdata;
    logic         np_arb_read;
    logic [31:0]  np_arb_address;
    logic         np_arb_resp;
    logic [255:0] np_arb_rdata;
    logic [31:0]  np_pf_hits;

    int n_checks = 0;
    int n_errors = 0;

    icache_prefetch_buffer u_dut (
        .clk(clk), .reset_n(reset_n),
        .icache_read(icache_read), .icache_address(icache_address),
        .icache_resp(icache_resp), .icache_rdata(icache_rdata),
        .arb_read(arb_read), .arb_address(arb_address),
        .arb_resp(arb_resp), .arb_rdata(arb_rdata),
        .pf_hits(pf_hits)
    );

    icache_prefetch_buffer #(.PREFETCH_EN(1'b0)) u_np (
        .clk(clk), .reset_n(reset_n),
        .icache_read(np_read), .icache_address(np_address),
        .icache_resp(np_resp), .icache_rdata(np_rdata),
        .arb_read(np_arb_read), .arb_address(np_arb_address),
        .arb_resp(np_arb_resp), .arb_rdata(np_arb_rdata),
        .pf_hits(np_pf_hits)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Distinct recognisable content per line address
    function automatic logic [255:0] line_of(input logic [31:0] a);
        return {8{a ^ 32'hC0DE_0000}};
    endfunction

    // Advance past the next rising edge; sample/drive 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        icache_read = 1'b0; icache_address = '0;
        arb_resp = 1'b0; arb_rdata = '0;
        np_read = 1'b0; np_address = '0;
        np_arb_resp = 1'b0; np_arb_rdata = '0;
        tick(); tick();
        n_checks++; if (arb_read !== 1'b0) begin n_errors++; $display("FAIL reset_arb_read got=%0b exp=0", arb_read); end
        n_checks++; if (arb_address !== 32'h0) begin n_errors++; $display("FAIL reset_arb_address got=%h exp=0", arb_address); end
        n_checks++; if (icache_resp !== 1'b0) begin n_errors++; $display("FAIL reset_icache_resp got=%0b exp=0", icache_resp); end
        n_checks++; if (icache_rdata !== 256'h0) begin n_errors++; $display("FAIL reset_icache_rdata got=%h exp=0", icache_rdata); end
        n_checks++; if (pf_hits !== 32'h0) begin n_errors++; $display("FAIL reset_pf_hits got=%0d exp=0", pf_hits); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_cold_miss();
        icache_read = 1'b1; icache_address = 32'h0000_0040;
        tick();
        n_checks++; if (icache_resp !== 1'b0) begin n_errors++; $display("FAIL cold_no_early_resp got=%0b exp=0", icache_resp); end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (arb_read !== 1'b1 || arb_address !== 32'h40) begin n_errors++; $display("FAIL cold_arb_hold cyc=%0d got=%0b/%h exp=1/00000040", i, arb_read, arb_address); end
            if (i == 4) begin arb_resp = 1'b1; arb_rdata = line_of(32'h40); end
            tick();
        end
        arb_resp = 1'b0; arb_rdata = '0;
        n_checks++; if (icache_resp !== 1'b1 || icache_rdata !== line_of(32'h40)) begin n_errors++; $display("FAIL cold_resp got=%0b/%h exp=1/%h", icache_resp, icache_rdata, line_of(32'h40)); end
        n_checks++; if (arb_read !== 1'b0) begin n_errors++; $display("FAIL cold_arb_drop got=%0b exp=0", arb_read); end
        icache_read = 1'b0; icache_address = '0;
        tick();
        n_checks++; if (arb_read !== 1'b1 || arb_address !== 32'h60) begin n_errors++; $display("FAIL cold_prefetch_launch got=%0b/%h exp=1/00000060", arb_read, arb_address); end
        n_checks++; if (icache_resp !== 1'b0 || icache_rdata !== 256'h0) begin n_errors++; $display("FAIL cold_resp_cleared got=%0b/%h exp=0/0", icache_resp, icache_rdata); end
    endtask

    task automatic test_sequential_hit();
        tick();
        arb_resp = 1'b1; arb_rdata = line_of(32'h60);
        tick();
        arb_resp = 1'b0; arb_rdata = '0;
        n_checks++; if (arb_read !== 1'b0) begin n_errors++; $display("FAIL seq_prefetch_done got=%0b exp=0", arb_read); end
        icache_read = 1'b1; icache_address = 32'h0000_0064;
        tick();
        n_checks++; if (icache_resp !== 1'b1 || icache_rdata !== line_of(32'h60)) begin n_errors++; $display("FAIL seq_hit_resp got=%0b/%h exp=1/%h", icache_resp, icache_rdata, line_of(32'h60)); end
        n_checks++; if (arb_read !== 1'b0) begin n_errors++; $display("FAIL seq_hit_no_arb got=%0b exp=0", arb_read); end
        n_checks++; if (pf_hits !== 32'd1) begin n_errors++; $display("FAIL seq_pf_hits got=%0d exp=1", pf_hits); end
        icache_read = 1'b0; icache_address = '0;
        tick();
        n_checks++; if (arb_read !== 1'b1 || arb_address !== 32'h80) begin n_errors++; $display("FAIL seq_next_prefetch got=%0b/%h exp=1/00000080", arb_read, arb_address); end
    endtask

    task automatic test_matched_during_prefetch();
        icache_read = 1'b1; icache_address = 32'h0000_0080;
        tick();
        n_checks++; if (arb_read !== 1'b1 || arb_address !== 32'h80 || icache_resp !== 1'b0) begin n_errors++; $display("FAIL match_wait got=%0b/%h/%0b exp=1/00000080/0", arb_read, arb_address, icache_resp); end
        arb_resp = 1'b1; arb_rdata = line_of(32'h80);
        tick();
        arb_resp = 1'b0; arb_rdata = '0;
        n_checks++; if (arb_read !== 1'b0 || icache_resp !== 1'b0) begin n_errors++; $display("FAIL match_idle_gap got=%0b/%0b exp=0/0", arb_read, icache_resp); end
        tick();
        n_checks++; if (icache_resp !== 1'b1 || icache_rdata !== line_of(32'h80)) begin n_errors++; $display("FAIL match_resp got=%0b/%h exp=1/%h", icache_resp, icache_rdata, line_of(32'h80)); end
        n_checks++; if (arb_read !== 1'b0) begin n_errors++; $display("FAIL match_no_second_arb got=%0b exp=0", arb_read); end
        n_checks++; if (pf_hits !== 32'd2) begin n_errors++; $display("FAIL match_pf_hits got=%0d exp=2", pf_hits); end
        icache_read = 1'b0; icache_address = '0;
        tick();
        n_checks++; if (arb_read !== 1'b1 || arb_address !== 32'hA0) begin n_errors++; $display("FAIL match_next_prefetch got=%0b/%h exp=1/000000a0", arb_read, arb_address); end
    endtask

    task automatic test_mismatched_during_prefetch();
        icache_read = 1'b1; icache_address = 32'h0000_0200;
        tick();
        n_checks++; if (arb_read !== 1'b1 || arb_address !== 32'hA0) begin n_errors++; $display("FAIL mis_addr_held got=%0b/%h exp=1/000000a0", arb_read, arb_address); end
        tick();
        n_checks++; if (arb_address !== 32'hA0 || icache_resp !== 1'b0) begin n_errors++; $display("FAIL mis_addr_held2 got=%h/%0b exp=000000a0/0", arb_address, icache_resp); end
        arb_resp = 1'b1; arb_rdata = line_of(32'hA0);
        tick();
        arb_resp = 1'b0; arb_rdata = '0;
        n_checks++; if (arb_read !== 1'b0 || arb_address !== 32'h0) begin n_errors++; $display("FAIL mis_idle_gap got=%0b/%h exp=0/0", arb_read, arb_address); end
        tick();
        n_checks++; if (arb_read !== 1'b1 || arb_address !== 32'h200) begin n_errors++; $display("FAIL mis_demand got=%0b/%h exp=1/00000200", arb_read, arb_address); end
        arb_resp = 1'b1; arb_rdata = line_of(32'h200);
        tick();
        arb_resp = 1'b0; arb_rdata = '0;
        n_checks++; if (icache_resp !== 1'b1 || icache_rdata !== line_of(32'h200)) begin n_errors++; $display("FAIL mis_resp got=%0b/%h exp=1/%h", icache_resp, icache_rdata, line_of(32'h200)); end
        n_checks++; if (pf_hits !== 32'd2) begin n_errors++; $display("FAIL mis_pf_hits got=%0d exp=2", pf_hits); end
        icache_read = 1'b0; icache_address = '0;
        tick();
        n_checks++; if (arb_read !== 1'b1 || arb_address !== 32'h220) begin n_errors++; $display("FAIL mis_next_prefetch got=%0b/%h exp=1/00000220", arb_read, arb_address); end
        arb_resp = 1'b1; arb_rdata = line_of(32'h220);
        tick();
        arb_resp = 1'b0; arb_rdata = '0;
    endtask

    task automatic test_wrap();
        icache_read = 1'b1; icache_address = 32'hFFFF_FFE4;
        tick();
        n_checks++; if (arb_read !== 1'b1 || arb_address !== 32'hFFFF_FFE0) begin n_errors++; $display("FAIL wrap_demand got=%0b/%h exp=1/ffffffe0", arb_read, arb_address); end
        arb_resp = 1'b1; arb_rdata = line_of(32'hFFFF_FFE0);
        tick();
        arb_resp = 1'b0; arb_rdata = '0;
        n_checks++; if (icache_resp !== 1'b1 || icache_rdata !== line_of(32'hFFFF_FFE0)) begin n_errors++; $display("FAIL wrap_resp got=%0b/%h exp=1/%h", icache_resp, icache_rdata, line_of(32'hFFFF_FFE0)); end
        icache_read = 1'b0; icache_address = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (arb_read !== 1'b0 || arb_address !== 32'h0 || icache_resp !== 1'b0) begin n_errors++; $display("FAIL wrap_no_prefetch cyc=%0d got=%0b/%h/%0b exp=0/0/0", i, arb_read, arb_address, icache_resp); end
        end
    endtask

    task automatic test_back_to_back();
        // Pass-through instance: two consecutive lines both go downstream
        np_read = 1'b1; np_address = 32'h0;
        tick();
        n_checks++; if (np_arb_read !== 1'b1 || np_arb_address !== 32'h0) begin n_errors++; $display("FAIL np_demand0 got=%0b/%h exp=1/0", np_arb_read, np_arb_address); end
        np_arb_resp = 1'b1; np_arb_rdata = line_of(32'h0);
        tick();
        np_arb_resp = 1'b0; np_arb_rdata = '0;
        n_checks++; if (np_resp !== 1'b1 || np_rdata !== line_of(32'h0)) begin n_errors++; $display("FAIL np_resp0 got=%0b/%h exp=1/%h", np_resp, np_rdata, line_of(32'h0)); end
        np_address = 32'h20;
        tick();
        n_checks++; if (np_arb_read !== 1'b0 || np_resp !== 1'b0) begin n_errors++; $display("FAIL np_idle got=%0b/%0b exp=0/0", np_arb_read, np_resp); end
        tick();
        n_checks++; if (np_arb_read !== 1'b1 || np_arb_address !== 32'h20) begin n_errors++; $display("FAIL np_demand1 got=%0b/%h exp=1/00000020", np_arb_read, np_arb_address); end
        np_arb_resp = 1'b1; np_arb_rdata = line_of(32'h20);
        tick();
        np_arb_resp = 1'b0; np_arb_rdata = '0;
        n_checks++; if (np_resp !== 1'b1 || np_rdata !== line_of(32'h20)) begin n_errors++; $display("FAIL np_resp1 got=%0b/%h exp=1/%h", np_resp, np_rdata, line_of(32'h20)); end
        np_read = 1'b0; np_address = '0;
        tick();
        n_checks++; if (np_arb_read !== 1'b0 || np_pf_hits !== 32'd0) begin n_errors++; $display("FAIL np_no_prefetch got=%0b/%0d exp=0/0", np_arb_read, np_pf_hits); end
    endtask

    task automatic test_async_reset();
        // Buffer currently holds line 0x220; start a demand to 0x300
        icache_read = 1'b1; icache_address = 32'h0000_0300;
        tick();
        n_checks++; if (arb_read !== 1'b1 || arb_address !== 32'h300) begin n_errors++; $display("FAIL rst_pre_demand got=%0b/%h exp=1/00000300", arb_read, arb_address); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (arb_read !== 1'b0 || arb_address !== 32'h0) begin n_errors++; $display("FAIL rst_async_arb got=%0b/%h exp=0/0", arb_read, arb_address); end
        n_checks++; if (icache_resp !== 1'b0 || icache_rdata !== 256'h0 || pf_hits !== 32'h0) begin n_errors++; $display("FAIL rst_async_outputs got=%0b/%h/%0d exp=0/0/0", icache_resp, icache_rdata, pf_hits); end
        icache_read = 1'b0; icache_address = '0;
        #1 reset_n = 1'b1;
        icache_read = 1'b1; icache_address = 32'h0000_0220;
        tick();
        n_checks++; if (arb_read !== 1'b1 || arb_address !== 32'h220 || icache_resp !== 1'b0) begin n_errors++; $display("FAIL rst_buffer_cleared got=%0b/%h/%0b exp=1/00000220/0", arb_read, arb_address, icache_resp); end
        arb_resp = 1'b1; arb_rdata = line_of(32'h220);
        tick();
        arb_resp = 1'b0; arb_rdata = '0;
        n_checks++; if (icache_resp !== 1'b1 || icache_rdata !== line_of(32'h220) || pf_hits !== 32'd0) begin n_errors++; $display("FAIL rst_post_resp got=%0b/%h/%0d exp=1/%h/0", icache_resp, icache_rdata, pf_hits, line_of(32'h220)); end
        icache_read = 1'b0; icache_address = '0;
        tick();
        n_checks++; if (arb_read !== 1'b1 || arb_address !== 32'h240) begin n_errors++; $display("FAIL rst_post_prefetch got=%0b/%h exp=1/00000240", arb_read, arb_address); end
        arb_resp = 1'b1; arb_rdata = line_of(32'h240);
        tick();
        arb_resp = 1'b0; arb_rdata = '0;
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_sequential_hit();
        test_matched_during_prefetch();
        test_mismatched_during_prefetch();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/icache_prefetch_buffer.md
# icache_prefetch_buffer

Single-entry next-line prefetch buffer between the instruction cache and the memory arbiter. It forwards icache line misses to the arbiter and returns the 256-bit line. After each response it fetches the sequentially next 32-byte line into a local buffer, so a later icache miss to that line is served without an arbiter round trip. The block is transparent to the icache protocol and keeps one arbiter request outstanding at most.

## Interface
- PREFETCH_EN, default 1: 1 = issue next-line prefetches; 0 = pure pass-through with one registered response cycle.
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- icache_read  in  1  line read request; held with icache_address until icache_resp.
- icache_address  in  32  request address; bits [4:0] ignored.
- icache_resp  out  1  single-cycle response pulse.
- icache_rdata  out  256  line data, valid while icache_resp=1.
- arb_read  out  1  downstream read; held high with arb_address stable until arb_resp.
- arb_address  out  32  line-aligned address; bits [4:0] always 0.
- arb_resp  in  1  downstream completion pulse.
- arb_rdata  in  256  downstream line, valid with arb_resp.
- pf_hits  out  32  count of requests served from the buffer; saturates at 0xFFFFFFFF.

## Operation
- State: buf_line[255:0], buf_tag[26:0], buf_valid, req_tag[26:0], out_line[255:0], FSM in {IDLE, DEMAND, RESP, PREFETCH}.
- IDLE:
  - If icache_read=0, stay.
  - Hit: icache_read=1, buf_valid=1 and buf_tag==icache_address[31:5]. Do out_line<=buf_line, req_tag<=address[31:5], pf_hits++ (saturating), go to RESP.
  - Miss: icache_read=1 and not a hit. Do req_tag<=address[31:5], go to DEMAND.
- DEMAND: arb_read=1, arb_address={req_tag,5'b0}. On arb_resp, out_line<=arb_rdata and go to RESP.
- RESP: icache_resp=1, icache_rdata=out_line. icache_read is ignored in this cycle. Next state:
  - If PREFETCH_EN=1 and req_tag!=27'h7FFFFFF: buf_valid<=0, buf_tag<=req_tag+1, go to PREFETCH.
  - Otherwise go to IDLE. This covers last-line wrap-around: no prefetch past 0xFFFFFFE0.
- PREFETCH: arb_read=1, arb_address={buf_tag,5'b0}. On arb_resp, buf_line<=arb_rdata, buf_valid<=1, go to IDLE.
- An icache request arriving during PREFETCH is not accepted. The prefetch always runs to completion, since the arbiter handshake cannot be aborted. The request is evaluated in IDLE on the following cycle: a hit if it targets the prefetched line, otherwise a miss.
- Coherence: icache lines are read-only, so the buffer is never invalidated except when a new prefetch launches and at reset.
- The buffer is not consumed on a hit. It is overwritten by the prefetch launched from RESP.

## Timing
- Reset (reset_n=0, asynchronous) forces:
  - FSM=IDLE, buf_valid=0, buf_tag=0, req_tag=0, out_line=0, buf_line=0, pf_hits=0.
  - Outputs: arb_read=0, arb_address=0, icache_resp=0, icache_rdata=0.
- Reset mid-DEMAND or mid-PREFETCH drops arb_read immediately. The arbiter and caches share this reset, so no half-completed transfer survives.
- When not in DEMAND/PREFETCH: arb_read=0, arb_address=0.
- When not in RESP: icache_resp=0, icache_rdata=0.
- Hit latency: icache_read sampled in IDLE at edge t, icache_resp high in cycle t+1.
- Miss latency:
  - arb_read rises the cycle after the request is sampled.
  - icache_resp is high the cycle after arb_resp, so the response is registered and there is no combinational arb-to-icache path.
- Prefetch launch: arb_read for the next line rises the cycle after icache_resp.
- Request during PREFETCH: at least one IDLE cycle separates arb_resp from the next DEMAND's arb_read.
- arb_read never deasserts before arb_resp. arb_address never changes while arb_read=1.

## Test plan
- Cold miss: request 0x00000040, arb_resp after 5 cycles with line D0.
  - Required: arb_address=0x40 held until arb_resp; icache_resp with D0 one cycle after arb_resp.
  - Required: arb_read for 0x60 on the next cycle.
- Sequential hit: prefetch of 0x60 completes with D1, then request 0x64.
  - Required: icache_resp with D1 one cycle after acceptance, with no arb_read for 0x60.
  - Required: prefetch of 0x80 starts next; pf_hits=1.
- Mismatched request during prefetch: request 0x200 while prefetch 0x80 is outstanding.
  - Required: arb_address stays 0x80 until arb_resp, then one IDLE cycle.
  - Required: arb_read for 0x200, icache_resp with that line, then prefetch of 0x220.
- Matched request during prefetch: request 0x80 while prefetch 0x80 is outstanding, arb_resp with D2.
  - Required: no second arb_read for 0x80; icache_resp with D2 two cycles after arb_resp; pf_hits increments.
- Wrap and disable:
  - Miss at 0xFFFFFFE4: response returned, no prefetch, FSM back to IDLE.
  - With PREFETCH_EN=0: back-to-back requests to 0x0 and 0x20 both go to the arbiter, and pf_hits stays 0.
- Async reset: pulse reset_n low mid-DEMAND between clock edges.
  - Required: arb_read=0 immediately, all outputs 0.
  - Required: after release, a request to the previously prefetched address misses.
